// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction arbiter: the 24-bit master descriptor,
// response error codes and the arbiter FSM states.
package i2c_pkg;

  typedef struct packed {
    logic [7:0] din;
    logic [7:0] addr;
    logic       op;
    logic [6:0] slv_addr;
  } i2c_desc_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NACK    = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_err_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_RD  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at N, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  logic found;
  int   cand;

  // NOTE: blocking assignments here so each loop iteration sees 'found' from
  // the previous one; every output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters: round-robin grant, one
// transaction in flight, ACK/read-data tracking, timeout and per-requester response.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*7-1:0] req_slv_addr,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ*8-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic                 m_i2c_trigger,
  output logic [23:0]          m_addr_data_out,
  output logic                 m_valid_addr_data_out,
  input  logic                 m_valid_data_ack,
  input  logic                 m_valid_data_ack_valid,
  input  logic [7:0]           m_rdata_out,
  input  logic                 m_rdata_out_valid,
  output logic                 m_rdata_out_valid_ack,
  input  logic                 m_pending_wr,
  input  logic                 m_pending_rd
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  i2c_desc_t          desc;
  i2c_desc_t          sel_desc;
  logic [7:0]         rdata_q;
  rsp_err_e           err_q;
  logic [TW-1:0]      timer;
  logic               rd_ack_q;
  logic               timed_out;

  // Arbitration runs on the vector captured when leaving IDLE, so requests
  // that change during GRANT cannot alter the winner.
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req_q),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_desc.slv_addr = req_slv_addr[int'(arb_idx)*7 +: 7];
    sel_desc.op       = req_op[arb_idx];
    sel_desc.addr     = req_addr[int'(arb_idx)*8 +: 8];
    sel_desc.din      = req_op[arb_idx] ? 8'h00 : req_wdata[int'(arb_idx)*8 +: 8];
  end

  // The timer holds the number of wait cycles already completed.
  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      desc     <= '0;
      rdata_q  <= '0;
      err_q    <= RSP_OK;
      timer    <= '0;
      rd_ack_q <= 1'b0;
    end else begin
      rd_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid && !m_pending_wr && !m_pending_rd) begin
            req_q <= req_valid;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          gnt_idx <= arb_idx;
          desc    <= sel_desc;
          rr_ptr  <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IW'(1);
          state   <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          timer   <= '0;
          rdata_q <= '0;
          err_q   <= RSP_OK;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          timer <= timer + TW'(1);
          if (m_valid_data_ack_valid) begin
            if (!m_valid_data_ack) begin
              err_q <= RSP_NACK;
              state <= ST_RESP;
            end else if (desc.op) begin
              state <= ST_WAIT_RD;
            end else begin
              state <= ST_RESP;
            end
          end else if (timed_out) begin
            err_q <= RSP_TIMEOUT;
            state <= ST_RESP;
          end
        end
        ST_WAIT_RD: begin
          timer <= timer + TW'(1);
          if (m_rdata_out_valid) begin
            rdata_q  <= m_rdata_out;
            rd_ack_q <= 1'b1;
            state    <= ST_RESP;
          end else if (timed_out) begin
            err_q   <= RSP_TIMEOUT;
            rdata_q <= '0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so all are 0 out of reset.
  assign req_ready             = (state == ST_GRANT) ? arb_grant : '0;
  assign m_i2c_trigger         = (state == ST_LAUNCH);
  assign m_valid_addr_data_out = (state == ST_LAUNCH) || (state == ST_WAIT_ACK) ||
                                 (state == ST_WAIT_RD);
  assign m_addr_data_out       = m_valid_addr_data_out ? desc : '0;
  assign m_rdata_out_valid_ack = rd_ack_q;
  assign rsp_valid             = (state == ST_RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rsp_rdata             = (state == ST_RESP) ? rdata_q : '0;
  assign rsp_err               = (state == ST_RESP) ? err_q : RSP_OK;

endmodule
